// File: rtl/regfile_pkg.sv
// Shared parameters and types for the decode-stage register file.
// The address width and register count are tied together by the 32:1 read trees.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = 5'd31;

endpackage

// File: rtl/regfile_bypass_decoder.sv
// 5:32 write-enable decoder gated by the write strobe.
// The output is one-hot or all zero; the XZR enable can never assert.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic             en,
  input  reg_addr_t        sel,
  output logic [NREGS-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
    out[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/regfile_bypass_mux.sv
// Single-bit mux cells used to build the 32:1 read trees.
// Each read bit uses four 8:1 cells feeding one 4:1 cell.
module mux8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

module mux4_1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/regfile_bypass.sv
// 32 x 64 register file with one write port, two combinational read ports,
// a hardwired zero register and same-cycle write-to-read bypass.
module regfile_bypass
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  reg_addr_t        WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  reg_addr_t        ReadRegister1,
  input  reg_addr_t        ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] stored [ZERO_REG];
  reg_addr_t        rsel [2];

  decoder5_32 u_dec (
    .en  (RegWrite),
    .sel (WriteRegister),
    .out (wr_en)
  );

  // One enabled flop row per real register; XZR has no storage at all.
  for (genvar i = 0; i < ZERO_REG; i++) begin : g_row
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q <= '0;
      end else if (wr_en[i]) begin
        q <= WriteData;
      end
    end

    assign stored[i] = q;
  end

  assign rsel[0] = ReadRegister1;
  assign rsel[1] = ReadRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] tree;
    logic [WIDTH-1:0] data;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [NREGS-1:0] plane;
      logic [3:0]       bank;

      // Leg 31 of every bit plane stays tied low.
      always_comb begin
        plane = '0;
        for (int i = 0; i < ZERO_REG; i++) begin
          plane[i] = stored[i][b];
        end
      end

      for (genvar k = 0; k < 4; k++) begin : g_bank
        mux8_1 u_m8 (
          .d   (plane[k*8 +: 8]),
          .sel (rsel[p][2:0]),
          .y   (bank[k])
        );
      end

      mux4_1 u_m4 (
        .d   (bank),
        .sel (rsel[p][4:3]),
        .y   (tree[b])
      );
    end

    // wr_en indexed by the read address is exactly "writing the register being read".
    always_comb begin
      data = tree;
      if (reset || (rsel[p] == ZERO_ADDR)) begin
        data = '0;
      end else if (wr_en[rsel[p]]) begin
        data = WriteData;
      end
    end
  end

  assign ReadData1 = g_port[0].data;
  assign ReadData2 = g_port[1].data;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass: reset, full write/read
// sweep, zero register, bypass, port independence and reset during write.
module tb_regfile_bypass;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int tests;
  int fails;

  regfile_bypass dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++;
    if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_hold: rd1=%h rd2=%h want 0", ReadData1, ReadData2);
    end
    @(negedge clk);
    reset = 1'b0;
    do_write(5'd5, 64'hDEAD);
    ReadRegister1 = 5'd5;
    #1;
    tests++;
    if (ReadData1 !== 64'hDEAD) begin
      fails++;
      $display("[TB] FAIL x5_before_reset: got %h want %h", ReadData1, 64'hDEAD);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (ReadData1 !== 64'h0) begin
      fails++;
      $display("[TB] FAIL async_reset: got %h want 0", ReadData1);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      tests++;
      if (ReadData1 !== 64'h0 || ReadData2 !== 64'h0) begin
        fails++;
        $display("[TB] FAIL post_reset_idx%0d: rd1=%h rd2=%h want 0", i, ReadData1, ReadData2);
      end
    end
  endtask

  task automatic test_write_read_all();
    logic [63:0] exp1;
    logic [63:0] exp2;
    for (int i = 0; i < 31; i++) begin
      do_write(5'(i), 64'h1111_0000_0000_0000 + 64'(i));
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      exp1 = (i == 31) ? 64'h0 : 64'h1111_0000_0000_0000 + 64'(i);
      exp2 = (i == 0)  ? 64'h0 : 64'h1111_0000_0000_0000 + 64'(31 - i);
      #1;
      tests++;
      if (ReadData1 !== exp1 || ReadData2 !== exp2) begin
        fails++;
        $display("[TB] FAIL sweep_idx%0d: rd1=%h want %h rd2=%h want %h",
                 i, ReadData1, exp1, ReadData2, exp2);
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd30;
    #1;
    tests++;
    if (ReadData1 !== 64'h0 || ReadData2 !== 64'h1111_0000_0000_001E) begin
      fails++;
      $display("[TB] FAIL xzr_same_cycle: rd1=%h want 0 rd2=%h want %h",
               ReadData1, ReadData2, 64'h1111_0000_0000_001E);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    tests++;
    if (ReadData1 !== 64'h0) begin
      fails++;
      $display("[TB] FAIL xzr_after_edge: got %h want 0", ReadData1);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ReadData1 !== 64'h0 || ReadData2 !== 64'h1111_0000_0000_001E) begin
      fails++;
      $display("[TB] FAIL xzr_later: rd1=%h want 0 rd2=%h want %h",
               ReadData1, ReadData2, 64'h1111_0000_0000_001E);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 64'hA);
    @(negedge clk);
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    tests++;
    if (ReadData1 !== 64'hA || ReadData2 !== 64'hA) begin
      fails++;
      $display("[TB] FAIL bypass_pre: rd1=%h rd2=%h want a", ReadData1, ReadData2);
    end
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'hB;
    #1;
    tests++;
    if (ReadData1 !== 64'hB || ReadData2 !== 64'hB) begin
      fails++;
      $display("[TB] FAIL bypass_before_edge: rd1=%h rd2=%h want b", ReadData1, ReadData2);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ReadData1 !== 64'hB || ReadData2 !== 64'hB) begin
      fails++;
      $display("[TB] FAIL bypass_after_edge: rd1=%h rd2=%h want b", ReadData1, ReadData2);
    end
    RegWrite  = 1'b0;
    WriteData = 64'hC;
    #1;
    tests++;
    if (ReadData1 !== 64'hB || ReadData2 !== 64'hB) begin
      fails++;
      $display("[TB] FAIL bypass_off_stored: rd1=%h rd2=%h want b", ReadData1, ReadData2);
    end
  endtask

  task automatic test_independence();
    do_write(5'd3, 64'h3);
    @(negedge clk);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    RegWrite      = 1'b1;
    WriteRegister = 5'd4;
    WriteData     = 64'h44;
    #1;
    tests++;
    if (ReadData1 !== 64'h3 || ReadData2 !== 64'h44) begin
      fails++;
      $display("[TB] FAIL independence: rd1=%h want 3 rd2=%h want 44", ReadData1, ReadData2);
    end
    @(posedge clk);
    #1;
    RegWrite  = 1'b0;
    WriteData = 64'h0;
    #1;
    tests++;
    if (ReadData1 !== 64'h3 || ReadData2 !== 64'h44) begin
      fails++;
      $display("[TB] FAIL independence_stored: rd1=%h want 3 rd2=%h want 44", ReadData1, ReadData2);
    end
  endtask

  task automatic test_reset_during_write();
    @(negedge clk);
    ReadRegister1 = 5'd2;
    #1;
    tests++;
    if (ReadData1 !== 64'h1111_0000_0000_0002) begin
      fails++;
      $display("[TB] FAIL x2_before: got %h want %h", ReadData1, 64'h1111_0000_0000_0002);
    end
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    WriteData     = 64'h22;
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (ReadData1 !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_suppresses_bypass: got %h want 0", ReadData1);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (ReadData1 !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_during_write: got %h want 0", ReadData1);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;

    test_reset();
    test_write_read_all();
    test_zero_reg();
    test_bypass();
    test_independence();
    test_reset_during_write();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
